fifo_wr_ctrl: RTL
=================

FIFO_WR_CTRL -- requirements
Module: fifo_wr_ctrl

Interface
REQ-001: Parameter FIFO_DEPTH, default 8, number of entries in the downstream FIFO memory; SHALL equal 2**Address.
REQ-002: Parameter Address, default 3, memory address width; pointers are Address+1 bits.
REQ-003: Parameter AF_THRESH, default 6, occupancy at or above which W_ALMOST_FULL asserts; SHALL lie in 1..FIFO_DEPTH.
REQ-004: W_CLK  input  1  write-domain clock; all state updates on its rising edge; the block SHALL use no other clock.
REQ-005: W_RST  input  1  asynchronous active-low reset.
REQ-006: W_INC  input  1  write request from the producer; one entry per cycle while high.
REQ-007: WQ2_RPTR  input  Address+1  Gray-coded read pointer, already two-flop synchronised into W_CLK.
REQ-008: OVF_CLR  input  1  synchronous clear of W_OVERFLOW.
REQ-009: W_CKEN  output  1  write enable to the FIFO memory.
REQ-010: WR_ADDR  output  Address  write address to the FIFO memory.
REQ-011: GRAY_WPTR  output  Address+1  registered Gray write pointer, sent to the read-domain synchroniser.
REQ-012: W_FULL  output  1  registered full flag.
REQ-013: W_ALMOST_FULL  output  1  registered almost-full flag.
REQ-014: W_LEVEL  output  Address+1  registered write-side occupancy estimate, 0..FIFO_DEPTH.
REQ-015: W_OVERFLOW  output  1  sticky error, set when a write is attempted while full.

Function
REQ-016: Internal binary pointer wbin, Address+1 bits, SHALL increment by 1 modulo 2**(Address+1) on a rising edge where W_CKEN=1, otherwise hold.
REQ-017: W_CKEN SHALL be combinational W_INC AND NOT W_FULL.
REQ-018: WR_ADDR SHALL be combinational wbin[Address-1:0], giving zero-latency address to the memory write in the same cycle.
REQ-019: wbin_next = wbin + W_CKEN; GRAY_WPTR SHALL register (wbin_next >> 1) XOR wbin_next each edge, so exactly one bit changes per increment.
REQ-020: W_FULL SHALL register 1 when gray(wbin_next) equals WQ2_RPTR with its two MSBs inverted and remaining bits equal; else 0.
REQ-021: rbin SHALL be the combinational Gray-to-binary conversion of WQ2_RPTR: rbin[MSB]=g[MSB], rbin[i]=rbin[i+1] XOR g[i].
REQ-022: W_LEVEL SHALL register (wbin_next - rbin) modulo 2**(Address+1); the result never exceeds FIFO_DEPTH.
REQ-023: W_ALMOST_FULL SHALL register 1 when (wbin_next - rbin) >= AF_THRESH, else 0.
REQ-024: W_FULL, W_LEVEL, and W_ALMOST_FULL take effect the cycle after the causing write; a write on the filling cycle is accepted, and the next W_INC is rejected.
REQ-025: Read-pointer advance and write in the same cycle: both SHALL be reflected in the next registered flags; a write presented while W_FULL=1 SHALL be rejected even if WQ2_RPTR advances that cycle.
REQ-026: W_OVERFLOW SHALL set on an edge with W_INC=1 and W_FULL=1, clear on an edge with OVF_CLR=1, and otherwise hold; set SHALL take priority over clear.
REQ-027: Rejected writes SHALL leave wbin, WR_ADDR, and GRAY_WPTR unchanged.
REQ-028: Pointer wrap from 2**(Address+1)-1 to 0 SHALL occur without disturbing the full or level computations.

Reset
REQ-029: W_RST low SHALL immediately force wbin=0, GRAY_WPTR=0, W_FULL=0, W_ALMOST_FULL=0, W_LEVEL=0, and W_OVERFLOW=0.
REQ-030: While W_RST is low, W_CKEN SHALL be 0 whenever W_INC=0, and memory writes SHALL be blocked by the memory's own reset.
REQ-031: Reset mid-burst SHALL discard all pointer state; the first accepted write after release SHALL go to WR_ADDR=0.

Verification
REQ-032: Reset, then hold WQ2_RPTR=0 -> WR_ADDR=0, GRAY_WPTR=4'b0000, W_FULL=0, W_LEVEL=0, W_OVERFLOW=0.
REQ-033: Eight consecutive W_INC with WQ2_RPTR=0 -> WR_ADDR steps 0..7 with W_CKEN=1; after the 8th write, GRAY_WPTR=4'b1100, W_FULL=1, W_LEVEL=8; W_ALMOST_FULL=1 from the cycle after the 6th write.
REQ-034: Ninth W_INC while full -> W_CKEN=0, WR_ADDR stays 0, W_OVERFLOW=1; W_OVERFLOW stays 1 until OVF_CLR pulses, then returns to 0.
REQ-035: From full, drive WQ2_RPTR=4'b0001 -> next cycle W_FULL=0, W_LEVEL=7; the next W_INC is accepted at WR_ADDR=0.
REQ-036: Sixteen writes with WQ2_RPTR tracking the write pointer two cycles behind -> W_FULL never asserts, and GRAY_WPTR returns to 4'b0000 after the 16th write (wrap).
REQ-037: Assert W_RST after 5 writes -> all outputs zero immediately; after release, the first write uses WR_ADDR=0 and W_LEVEL=1.

Source files
------------

// File: rtl/fifo_wr_ctrl.sv
// Write-side controller of an asynchronous FIFO.
// Keeps the binary/Gray write pointer and drives the memory write enable and
// address. It also compares against the synchronised Gray read pointer to
// produce registered full, almost-full, occupancy and sticky overflow flags.
module fifo_wr_ctrl #(
  parameter int FIFO_DEPTH = 8,
  parameter int Address    = 3,
  parameter int AF_THRESH  = 6
) (
  input  logic               W_CLK,
  input  logic               W_RST,
  input  logic               W_INC,
  input  logic [Address:0]   WQ2_RPTR,
  input  logic               OVF_CLR,
  output logic               W_CKEN,
  output logic [Address-1:0] WR_ADDR,
  output logic [Address:0]   GRAY_WPTR,
  output logic               W_FULL,
  output logic               W_ALMOST_FULL,
  output logic [Address:0]   W_LEVEL,
  output logic               W_OVERFLOW
);

  localparam int PW = Address + 1;
  // An out-of-range threshold is clamped to the memory depth
  localparam int AF_LIM = (AF_THRESH > FIFO_DEPTH) ? FIFO_DEPTH : AF_THRESH;
  localparam logic [PW-1:0] AF_VAL = PW'(AF_LIM);

  logic [PW-1:0] wbin_reg;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] gray_next;
  logic [PW-1:0] rbin;
  logic [PW-1:0] level_next;
  logic [PW-1:0] full_match;
  logic          full_next;
  logic          af_next;
  logic          ovf_next;

  // Each binary bit of the read pointer is the XOR of all Gray bits at and above it
  genvar gi;
  generate
    for (gi = 0; gi < PW; gi++) begin : g_g2b
      assign rbin[gi] = ^WQ2_RPTR[PW-1:gi];
    end
  endgenerate

  // A write is only accepted while the registered full flag is clear
  assign W_CKEN  = W_INC & ~W_FULL;
  assign WR_ADDR = wbin_reg[Address-1:0];

  // Full occurs when the next write pointer is one lap ahead of the read pointer:
  // in Gray code that means the two MSBs differ and the rest match.
  assign full_match = {~WQ2_RPTR[PW-1:PW-2], WQ2_RPTR[PW-3:0]};

  // Next-pointer and next-flag computation from the post-write pointer
  always_comb begin
    wbin_next  = wbin_reg + {{Address{1'b0}}, W_CKEN};
    gray_next  = (wbin_next >> 1) ^ wbin_next;
    level_next = wbin_next - rbin;
    full_next  = (gray_next == full_match);
    af_next    = (level_next >= AF_VAL);
    ovf_next   = W_OVERFLOW;
    if (W_INC && W_FULL) begin
      ovf_next = 1'b1;
    end else if (OVF_CLR) begin
      ovf_next = 1'b0;
    end
  end

  // Pointer and flag registers, cleared asynchronously
  always_ff @(posedge W_CLK or negedge W_RST) begin
    if (!W_RST) begin
      wbin_reg      <= '0;
      GRAY_WPTR     <= '0;
      W_FULL        <= 1'b0;
      W_ALMOST_FULL <= 1'b0;
      W_LEVEL       <= '0;
      W_OVERFLOW    <= 1'b0;
    end else begin
      wbin_reg      <= wbin_next;
      GRAY_WPTR     <= gray_next;
      W_FULL        <= full_next;
      W_ALMOST_FULL <= af_next;
      W_LEVEL       <= level_next;
      W_OVERFLOW    <= ovf_next;
    end
  end

endmodule
